// File: rtl/inst_encoder.sv
// inst_encoder: encodes R/LOAD/STORE/BRANCH requests into RV32 words, queues them in a FIFO and tags each with a byte address
module inst_encoder #(
  parameter int DEPTH = 4,
  parameter logic [31:0] BASE_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_fmt,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [12:0] imm,
  input  logic        base_load,
  input  logic [31:0] base_addr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_addr,
  output logic        err,
  output logic [15:0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [31:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] occ;
  logic [31:0] enc;
  logic full, acc, drop, push, pop;
  always_comb begin
    enc = req_fmt == 2'b00 ? {funct7, rs2, rs1, funct3, rd, 7'b0110011} :
          req_fmt == 2'b01 ? {imm[11:0], rs1, funct3, rd, 7'b0000011} :
          req_fmt == 2'b10 ? {imm[11:5], rs2, rs1, funct3, imm[4:0], 7'b0100011} :
                             {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], 7'b1100011};
    full = occ == (AW+1)'(DEPTH);
    req_ready = !full;
    out_valid = occ != '0;
    acc = req_valid && req_ready;
    // misaligned branches complete the handshake but never reach the FIFO
    drop = acc && req_fmt == 2'b11 && imm[0];
    push = acc && !drop;
    pop = out_valid && out_ready;
    out_inst = mem[rp];
  end
  always_ff @(posedge clk)
    if (push && !rst) mem[wp] <= enc;
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      occ <= '0;
      out_addr <= BASE_RESET;
      err <= 1'b0;
      count <= '0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop) rp <= rp + AW'(1);
      occ <= occ + (AW+1)'(push) - (AW+1)'(pop);
      out_addr <= base_load ? base_addr : pop ? out_addr + 32'd4 : out_addr;
      err <= err | drop;
      count <= pop && count != 16'hFFFF ? count + 16'd1 : count;
    end
  end
endmodule

// File: tb/tb_inst_encoder.sv
// tb_inst_encoder: randomized and directed checks of inst_encoder against a queue-based reference model
module tb_inst_encoder;
  localparam int DEPTH = 4;
  localparam logic [31:0] BASE = 32'h0000_0000;
  logic clk = 0, rst = 1, req_valid = 0, req_ready, base_load = 0, out_valid, out_ready = 0, err;
  logic [1:0] req_fmt = 0;
  logic [4:0] rd = 0, rs1 = 0, rs2 = 0;
  logic [2:0] funct3 = 0;
  logic [6:0] funct7 = 0;
  logic [12:0] imm = 0;
  logic [31:0] base_addr = 0, out_inst, out_addr;
  logic [15:0] count;
  int checks = 0, errors = 0;
  logic [31:0] q[$];
  logic [31:0] maddr;
  logic [15:0] mcnt;
  logic merr, live = 0;

  inst_encoder #(.DEPTH(DEPTH), .BASE_RESET(BASE)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_fmt(req_fmt),
    .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7), .imm(imm),
    .base_load(base_load), .base_addr(base_addr), .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_addr(out_addr), .err(err), .count(count));

  always #5 clk = ~clk;

  function automatic logic [31:0] em(input logic [1:0] f, input logic [4:0] d, s1, s2,
                                     input logic [2:0] f3, input logic [6:0] f7, input logic [12:0] im);
    logic [31:0] i, a, b, c, g, h, k;
    i = {{19{im[12]}}, im};
    a = 32'(d); b = 32'(s1); c = 32'(s2); g = 32'(f3); h = 32'(f7);
    k = (c << 20) | (b << 15) | (g << 12);
    case (f)
      2'd0: return (h << 25) | k | (a << 7) | 32'h33;
      2'd1: return ((i & 32'hFFF) << 20) | (b << 15) | (g << 12) | (a << 7) | 32'h03;
      2'd2: return (((i >> 5) & 32'h7F) << 25) | k | ((i & 32'h1F) << 7) | 32'h23;
      default: return (((i >> 12) & 32'h1) << 31) | (((i >> 5) & 32'h3F) << 25) | k |
                      (((i >> 1) & 32'hF) << 8) | (((i >> 11) & 32'h1) << 7) | 32'h63;
    endcase
  endfunction

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", n, a, e, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      q.delete(); maddr = BASE; mcnt = 0; merr = 0; live = 1;
    end else if (live) begin
      automatic bit p = q.size() > 0 && out_ready;
      automatic bit a = req_valid && q.size() < DEPTH;
      automatic bit dr = a && req_fmt == 2'd3 && imm[0];
      if (p) void'(q.pop_front());
      if (a && !dr) q.push_back(em(req_fmt, rd, rs1, rs2, funct3, funct7, imm));
      maddr = base_load ? base_addr : p ? maddr + 32'd4 : maddr;
      if (p && mcnt != 16'hFFFF) mcnt++;
      merr |= dr;
    end
  end

  always @(negedge clk) if (live) begin
    chk("req_ready", 32'(req_ready), 32'(q.size() < DEPTH));
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    if (q.size() != 0) chk("out_inst", out_inst, q[0]);
    chk("out_addr", out_addr, maddr);
    chk("err", 32'(err), 32'(merr));
    chk("count", 32'(count), 32'(mcnt));
  end

  task automatic nxt(input int n = 1);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic req(input logic [1:0] f, input logic [4:0] d, s1, s2, input logic [2:0] f3,
                     input logic [6:0] f7, input logic [12:0] im);
    req_valid = 1; req_fmt = f; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = im;
  endtask

  initial begin
    logic [31:0] first;
    nxt(2);
    rst = 0;
    req(2'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 13'h1ABC);
    nxt(); req_valid = 0;
    chk("add_valid", 32'(out_valid), 32'd1);
    chk("add_inst", out_inst, 32'h002081B3);
    chk("add_addr", out_addr, BASE);
    out_ready = 1; nxt(); out_ready = 0;
    req(2'd1, 5'd5, 5'd2, 5'd31, 3'd2, 7'h7F, 13'd8);
    nxt(); req_valid = 0;
    chk("lw_inst", out_inst, 32'h00812283);
    chk("lw_addr", out_addr, BASE + 32'd4);
    out_ready = 1; nxt(); out_ready = 0;
    req(2'd2, 5'd9, 5'd2, 5'd6, 3'd2, 7'h55, 13'd12);
    nxt(); req_valid = 0;
    chk("sw_inst", out_inst, 32'h00612623);
    chk("sw_addr", out_addr, BASE + 32'd8);
    out_ready = 1; nxt(); out_ready = 0;
    req(2'd3, 5'd17, 5'd1, 5'd2, 3'd0, 7'h11, 13'h1FF8);
    nxt(); req_valid = 0;
    chk("br_inst", out_inst, 32'hFE208CE3);
    out_ready = 1; nxt(); out_ready = 0;
    req(2'd3, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 13'h0003);
    nxt(); req_valid = 0;
    chk("br_mis_valid", 32'(out_valid), 32'd0);
    chk("br_mis_err", 32'(err), 32'd1);
    for (int i = 0; i < DEPTH; i++) begin
      req(2'd0, 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), 7'($urandom), 13'($urandom));
      if (i == 0) first = em(req_fmt, rd, rs1, rs2, funct3, funct7, imm);
      nxt();
    end
    req_valid = 0;
    chk("full_ready", 32'(req_ready), 32'd0);
    nxt(3);
    chk("hold_inst", out_inst, first);
    out_ready = 1; nxt(DEPTH);
    chk("drain_empty", 32'(out_valid), 32'd0);
    chk("drain_count", 32'(count), 32'd8);
    out_ready = 0;
    req(2'd1, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 13'd4);
    nxt();
    req(2'd1, 5'd2, 5'd2, 5'd2, 3'd0, 7'd0, 13'd8);
    out_ready = 1; base_load = 1; base_addr = 32'hFFFF_FFFC;
    nxt(); req_valid = 0; base_load = 0;
    chk("bl_addr", out_addr, 32'hFFFF_FFFC);
    chk("bl_popped", 32'(count), 32'd9);
    nxt();
    chk("wrap_addr", out_addr, 32'h0000_0000);
    out_ready = 0;
    for (int c = 0; c < 3000; c++) begin
      req_valid = 1'($urandom_range(0, 3) != 0);
      req(2'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), 7'($urandom), 13'($urandom));
      req_valid = 1'($urandom_range(0, 3) != 0);
      out_ready = 1'($urandom_range(0, 2) != 0);
      base_load = $urandom_range(0, 63) == 0;
      base_addr = $urandom;
      rst = $urandom_range(0, 499) == 0;
      nxt();
    end
    rst = 0; base_load = 0; out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      req(2'd0, 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), 7'($urandom), 13'($urandom));
      nxt();
    end
    req(2'd3, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 13'h0001);
    nxt();
    req_valid = 0; out_ready = 1; rst = 1;
    nxt(); rst = 0; out_ready = 0;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_addr", out_addr, BASE);
    nxt(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
